otp_ctrl_ecc_reg_scrub: RTL and testbench



---
 rtl/otp_ctrl_ecc_reg_scrub.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_otp_ctrl_ecc_reg_scrub.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_ctrl_ecc_reg_scrub.sv
// otp_ctrl_ecc_reg_scrub
//
// ECC-protected register file for buffered OTP partitions. Each word is stored
// together with an inverted SECDED check field. A single decoder serves the
// read port. A single sequential scrubber walks every word on request and
// reports errors into sticky status registers.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   wren_i/waddr_i/wdata_i     write port (out-of-range addresses ignored)
//   rden_i/raddr_i             read request, answered one cycle later
//   rvalid_o/rdata_o/rerr_o    read response, rerr_o = {double, single}
//   data_o                     concurrent raw contents, word i at [i*Width +: Width]
//   scrub_req_i                start a scan (ignored while busy)
//   scrub_busy_o/scrub_done_o  scan in progress / one-cycle completion pulse
//   clr_err_i                  clear sticky error status
//   ecc_err_o/err_addr_o/err_cnt_o  sticky flag, first error address, saturating count
//
// Optional feature macro: OTP_CTRL_ECC_REG_CORRECT_EN
//   defined   -> scrubber writes back corrected single-bit errors and rdata_o
//                returns corrected data
//   undefined -> detect-only, rdata_o is raw

module otp_ctrl_ecc_reg_scrub #(
    parameter int  Width    = 64,
    parameter int  Depth    = 128,
    parameter int  CntWidth = 8,
    localparam int Aw       = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wren_i,
    input  logic [Aw-1:0]          waddr_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   rden_i,
    input  logic [Aw-1:0]          raddr_i,
    output logic                   rvalid_o,
    output logic [Width-1:0]       rdata_o,
    output logic [1:0]             rerr_o,
    output logic [Depth*Width-1:0] data_o,
    input  logic                   scrub_req_i,
    output logic                   scrub_busy_o,
    output logic                   scrub_done_o,
    input  logic                   clr_err_i,
    output logic                   ecc_err_o,
    output logic [Aw-1:0]          err_addr_o,
    output logic [CntWidth-1:0]    err_cnt_o
);

    if (!(Width == 32 || Width == 64)) begin : gen_width_chk
        $error("otp_ctrl_ecc_reg_scrub: Width must be 32 or 64");
    end
    if (Depth < 2) begin : gen_depth_chk
        $error("otp_ctrl_ecc_reg_scrub: Depth must be at least 2");
    end

    localparam int EccWidth = (Width == 32) ? 7 : 8;
    // Inversion constant: the check field of an all-zero data word.
    localparam logic [EccWidth-1:0] ZeroEcc = (Width == 32) ? EccWidth'(7'h2A) : EccWidth'(8'h5A);
    localparam logic [Aw:0]         DepthW   = (Aw + 1)'(Depth);
    localparam logic [Aw-1:0]       LastAddr = Aw'(Depth - 1);

`ifdef OTP_CTRL_ECC_REG_CORRECT_EN
    localparam bit CorrectEn = 1'b1;
`else
    localparam bit CorrectEn = 1'b0;
`endif

    // Parity-check columns: distinct odd-weight vectors of weight >= 3. This
    // makes every single data-bit error produce a unique odd syndrome, every
    // check-bit error a weight-1 syndrome and every double error an even one.
    typedef logic [Width-1:0][EccWidth-1:0] cols_t;

    function automatic cols_t gen_cols();
        cols_t c;
        int    n;
        int    w;
        c = '0;
        n = 0;
        for (int v = 1; v < (1 << EccWidth); v++) begin
            w = 0;
            for (int b = 0; b < EccWidth; b++) begin
                w += (v >> b) & 1;
            end
            if (w >= 3 && w[0] && n < Width) begin
                c[n] = v[EccWidth-1:0];
                n++;
            end
        end
        return c;
    endfunction

    localparam cols_t Cols = gen_cols();

    function automatic logic [EccWidth-1:0] calc_parity(input logic [Width-1:0] d);
        logic [EccWidth-1:0] p;
        p = '0;
        for (int i = 0; i < Width; i++) begin
            if (d[i]) p ^= Cols[i];
        end
        return p;
    endfunction

    function automatic logic [EccWidth-1:0] enc(input logic [Width-1:0] d);
        return calc_parity(d) ^ ZeroEcc;
    endfunction

    // {double, single}: odd-weight syndrome is treated as a single error.
    function automatic logic [1:0] dec_err(input logic [Width-1:0] d, input logic [EccWidth-1:0] e);
        logic [EccWidth-1:0] syn;
        syn = calc_parity(d) ^ e ^ ZeroEcc;
        if (syn == '0) return 2'b00;
        return (^syn) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [Width-1:0] dec_fix(input logic [Width-1:0] d, input logic [EccWidth-1:0] e);
        logic [EccWidth-1:0] syn;
        logic [Width-1:0]    r;
        syn = calc_parity(d) ^ e ^ ZeroEcc;
        r   = d;
        for (int i = 0; i < Width; i++) begin
            if (syn == Cols[i]) r[i] = ~d[i];
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, SCAN, WBACK} state_e;

    logic [Width-1:0]    data_q [Depth];
    logic [EccWidth-1:0] ecc_q  [Depth];

    state_e              state_q, state_d;
    logic [Aw-1:0]       scan_addr_q, scan_addr_d;
    logic                done_q, done_d;
    logic                scrub_ev, step;
    logic [1:0]          scan_err;
    logic [Width-1:0]    scan_fix;
    logic                wr_ok, wb_en;

    logic                rvalid_q, rd_inr_q;
    logic [Aw-1:0]       rd_addr_q;
    logic [Width-1:0]    rd_data_q;
    logic [EccWidth-1:0] rd_ecc_q;
    logic [1:0]          rd_err;
    logic                rd_ev;

    logic                err_q, err_base;
    logic [Aw-1:0]       err_addr_q;
    logic [CntWidth-1:0] err_cnt_q, cnt_base;
    logic [1:0]          n_ev;
    logic [CntWidth:0]   cnt_sum;

    assign scan_err = dec_err(data_q[scan_addr_q], ecc_q[scan_addr_q]);
    assign scan_fix = dec_fix(data_q[scan_addr_q], ecc_q[scan_addr_q]);
    assign wr_ok    = wren_i && ({1'b0, waddr_i} < DepthW);
    // Any user write takes the array port; a same-address write also makes
    // the pending writeback obsolete (handled by the FSM stepping on).
    assign wb_en    = (state_q == WBACK) && !wren_i;

    // Storage: user writes have priority over scrubber writebacks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= '0;
                ecc_q[i]  <= ZeroEcc;
            end
        end else if (wr_ok) begin
            data_q[waddr_i] <= wdata_i;
            ecc_q[waddr_i]  <= enc(wdata_i);
        end else if (wb_en) begin
            data_q[scan_addr_q] <= scan_fix;
            ecc_q[scan_addr_q]  <= enc(scan_fix);
        end
    end

    for (genvar i = 0; i < Depth; i++) begin : gen_data_o
        assign data_o[i*Width +: Width] = data_q[i];
    end

    // The read captures the stored codeword at the request edge, so a
    // same-cycle write to that address is not visible (read-first).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q  <= 1'b0;
            rd_inr_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            rd_ecc_q  <= '0;
        end else begin
            rvalid_q <= rden_i;
            if (rden_i) begin
                rd_inr_q  <= ({1'b0, raddr_i} < DepthW);
                rd_addr_q <= raddr_i;
                rd_data_q <= data_q[raddr_i];
                rd_ecc_q  <= ecc_q[raddr_i];
            end
        end
    end

    assign rd_err   = dec_err(rd_data_q, rd_ecc_q);
    assign rd_ev    = rvalid_q && rd_inr_q && (rd_err != 2'b00);
    assign rvalid_o = rvalid_q;
    assign rerr_o   = (rvalid_q && rd_inr_q) ? rd_err : 2'b00;
    assign rdata_o  = !(rvalid_q && rd_inr_q) ? '0 :
                      CorrectEn ? dec_fix(rd_data_q, rd_ecc_q) : rd_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            scan_addr_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_addr_q <= scan_addr_d;
            done_q      <= done_d;
        end
    end

    // Scan stalls for any user write so the decode result always matches the
    // word that is actually stored. WBACK steps on after writing back, or at
    // once when a user write to the same word supersedes the correction.
    always_comb begin
        state_d     = state_q;
        scan_addr_d = scan_addr_q;
        done_d      = 1'b0;
        scrub_ev    = 1'b0;
        step        = 1'b0;
        case (state_q)
            IDLE: begin
                if (scrub_req_i) begin
                    state_d     = SCAN;
                    scan_addr_d = '0;
                end
            end
            SCAN: begin
                if (!wren_i) begin
                    scrub_ev = (scan_err != 2'b00);
                    if (CorrectEn && scan_err == 2'b01) state_d = WBACK;
                    else step = 1'b1;
                end
            end
            WBACK: begin
                step = !wren_i || (waddr_i == scan_addr_q);
            end
            default: state_d = IDLE;
        endcase
        if (step) begin
            if (scan_addr_q == LastAddr) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d     = SCAN;
                scan_addr_d = scan_addr_q + 1'b1;
            end
        end
    end

    assign scrub_busy_o = (state_q != IDLE);
    assign scrub_done_o = done_q;

    // A clear is applied first, then any error of the same cycle on top of it.
    assign n_ev     = {1'b0, scrub_ev} + {1'b0, rd_ev};
    assign err_base = err_q && !clr_err_i;
    assign cnt_base = clr_err_i ? '0 : err_cnt_q;
    assign cnt_sum  = {1'b0, cnt_base} + (CntWidth + 1)'(n_ev);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (clr_err_i) begin
                err_q      <= 1'b0;
                err_addr_q <= '0;
                err_cnt_q  <= '0;
            end
            if (n_ev != 2'b00) begin
                err_q     <= 1'b1;
                err_cnt_q <= cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
                if (!err_base) err_addr_q <= scrub_ev ? scan_addr_q : rd_addr_q;
            end
        end
    end

    assign ecc_err_o  = err_q;
    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_otp_ctrl_ecc_reg_scrub.sv
// Directed testbench for otp_ctrl_ecc_reg_scrub (Width 64, Depth 12, CntWidth 2).
// Errors are injected by overwriting stored data words hierarchically while
// leaving their check fields untouched.

module tb_otp_ctrl_ecc_reg_scrub;

    localparam int Width    = 64;
    localparam int Depth    = 12;
    localparam int CntWidth = 2;
    localparam int Aw       = 4;

`ifdef OTP_CTRL_ECC_REG_CORRECT_EN
    localparam bit CorrEn = 1'b1;
`else
    localparam bit CorrEn = 1'b0;
`endif

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   wren_i = 1'b0;
    logic [Aw-1:0]          waddr_i = '0;
    logic [Width-1:0]       wdata_i = '0;
    logic                   rden_i = 1'b0;
    logic [Aw-1:0]          raddr_i = '0;
    logic                   rvalid_o;
    logic [Width-1:0]       rdata_o;
    logic [1:0]             rerr_o;
    logic [Depth*Width-1:0] data_o;
    logic                   scrub_req_i = 1'b0;
    logic                   scrub_busy_o;
    logic                   scrub_done_o;
    logic                   clr_err_i = 1'b0;
    logic                   ecc_err_o;
    logic [Aw-1:0]          err_addr_o;
    logic [CntWidth-1:0]    err_cnt_o;

    int total = 0;
    int passed = 0;
    int failed = 0;

    logic [3:0]  wr_addr_tbl [4] = '{4'd0, 4'd1, 4'd2, 4'd11};
    logic [63:0] wr_data_tbl [4] = '{64'hA5A5_0000_1111_2222, 64'h0123_4567_89AB_CDEF,
                                     64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001};

    always #5 clk_i = ~clk_i;

    otp_ctrl_ecc_reg_scrub #(
        .Width    (Width),
        .Depth    (Depth),
        .CntWidth (CntWidth)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wren_i       (wren_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .rden_i       (rden_i),
        .raddr_i      (raddr_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .rerr_o       (rerr_o),
        .data_o       (data_o),
        .scrub_req_i  (scrub_req_i),
        .scrub_busy_o (scrub_busy_o),
        .scrub_done_o (scrub_done_o),
        .clr_err_i    (clr_err_i),
        .ecc_err_o    (ecc_err_o),
        .err_addr_o   (err_addr_o),
        .err_cnt_o    (err_cnt_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs from a falling edge and returns at the next one.
    task automatic applyStimulus(input logic wr, input logic [3:0] wa, input logic [63:0] wd,
                                 input logic rd, input logic [3:0] ra,
                                 input logic req, input logic clr);
        wren_i      = wr;
        waddr_i     = wa;
        wdata_i     = wd;
        rden_i      = rd;
        raddr_i     = ra;
        scrub_req_i = req;
        clr_err_i   = clr;
        @(negedge clk_i);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // Starts a scan and runs a fixed window counting busy cycles and done
    // pulses. A redundant request is issued mid-scan. Optionally issues four
    // back-to-back writes from cycle wr_at and a read of rd_addr at rd_at.
    task automatic runScrub(input int wr_at, input int rd_at, input logic [3:0] rd_addr,
                            output int busy, output int done);
        int  k;
        bit  w;
        busy = 0;
        done = 0;
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (scrub_busy_o) busy++;
            if (scrub_done_o) done++;
            if (rd_at >= 0 && i == rd_at + 2) begin
                checkOutput("dual_err_cnt", err_cnt_o, 2);
                checkOutput("dual_err_addr", err_addr_o, 2);
            end
            k = i - wr_at;
            w = (wr_at >= 0) && (k >= 0) && (k < 4);
            applyStimulus(w, w ? wr_addr_tbl[k[1:0]] : 4'd0, w ? wr_data_tbl[k[1:0]] : 64'd0,
                          (i == rd_at), rd_addr, (i == 3), 1'b0);
        end
    endtask

    initial begin
        int busy;
        int done;

        repeat (3) @(negedge clk_i);
        checkOutput("rst_busy", scrub_busy_o, 0);
        checkOutput("rst_done", scrub_done_o, 0);
        checkOutput("rst_rvalid", rvalid_o, 0);
        checkOutput("rst_rdata", rdata_o, 0);
        checkOutput("rst_err", ecc_err_o, 0);
        checkOutput("rst_cnt", err_cnt_o, 0);
        checkOutput("rst_addr", err_addr_o, 0);
        checkOutput("rst_data_o", |data_o, 0);
        rst_ni = 1'b1;

        // Clean array scrub
        runScrub(-1, -1, 4'd0, busy, done);
        checkOutput("t1_busy_cycles", busy, Depth);
        checkOutput("t1_done_pulses", done, 1);
        checkOutput("t1_err", ecc_err_o, 0);
        checkOutput("t1_cnt", err_cnt_o, 0);

        // Write then read, read-first, out-of-range read
        applyStimulus(1'b1, 4'd5, 64'hDEAD_BEEF_0123_4567, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, 4'd5, 1'b0, 1'b0);
        checkOutput("t2_rvalid", rvalid_o, 1);
        checkOutput("t2_rdata", rdata_o, 64'hDEAD_BEEF_0123_4567);
        checkOutput("t2_rerr", rerr_o, 0);
        applyStimulus(1'b1, 4'd5, 64'h1111, 1'b1, 4'd5, 1'b0, 1'b0);
        checkOutput("t2_readfirst", rdata_o, 64'hDEAD_BEEF_0123_4567);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, 4'd13, 1'b0, 1'b0);
        checkOutput("t2_oor_rvalid", rvalid_o, 1);
        checkOutput("t2_oor_rdata", rdata_o, 0);
        checkOutput("t2_oor_rerr", rerr_o, 0);
        idleCycle();
        checkOutput("t2_rvalid_drop", rvalid_o, 0);
        checkOutput("t2_data_o5", data_o[5*Width +: Width], 64'h1111);

        // Single error in word 3, double error in word 9
        dut.data_q[3] = 64'h1;
        dut.data_q[9] = 64'h3;
        runScrub(-1, -1, 4'd0, busy, done);
        checkOutput("t3_busy_cycles", busy, CorrEn ? Depth + 1 : Depth);
        checkOutput("t3_done_pulses", done, 1);
        checkOutput("t3_err", ecc_err_o, 1);
        checkOutput("t3_addr", err_addr_o, 3);
        checkOutput("t3_cnt", err_cnt_o, 2);
        checkOutput("t3_word3", data_o[3*Width +: Width], CorrEn ? 64'h0 : 64'h1);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, 4'd9, 1'b0, 1'b0);
        checkOutput("t3_rerr_double", rerr_o, 2'b10);
        checkOutput("t3_rdata_double", rdata_o, 64'h3);
        idleCycle();
        checkOutput("t3_read_cnt", err_cnt_o, 3);
        checkOutput("t3_read_addr", err_addr_o, 3);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("t3_clr_err", ecc_err_o, 0);
        checkOutput("t3_clr_cnt", err_cnt_o, 0);
        checkOutput("t3_clr_addr", err_addr_o, 0);
        runScrub(-1, -1, 4'd0, busy, done);
        checkOutput("t3_re_err", ecc_err_o, 1);
        checkOutput("t3_re_cnt", err_cnt_o, CorrEn ? 1 : 2);
        checkOutput("t3_re_addr", err_addr_o, CorrEn ? 9 : 3);
        dut.data_q[7] = 64'h100;
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, 4'd7, 1'b0, 1'b0);
        checkOutput("t3_rerr_single", rerr_o, 2'b01);
        checkOutput("t3_rdata_single", rdata_o, CorrEn ? 64'h0 : 64'h100);
        idleCycle();

        // Reset in the middle of a scan
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        repeat (4) idleCycle();
        checkOutput("t6_busy_pre", scrub_busy_o, 1);
        rst_ni = 1'b0;
        #1;
        checkOutput("t6_busy", scrub_busy_o, 0);
        checkOutput("t6_err", ecc_err_o, 0);
        checkOutput("t6_cnt", err_cnt_o, 0);
        checkOutput("t6_addr", err_addr_o, 0);
        checkOutput("t6_data_o", |data_o, 0);
        checkOutput("t6_rvalid", rvalid_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        busy = 0;
        done = 0;
        for (int i = 0; i < 20; i++) begin
            if (scrub_busy_o) busy++;
            if (scrub_done_o) done++;
            idleCycle();
        end
        checkOutput("t6_no_busy", busy, 0);
        checkOutput("t6_no_done", done, 0);

        // Four writes stall the scan; doubles at 4 and 10 must still be found
        dut.data_q[4]  = 64'h6;
        dut.data_q[10] = 64'h6;
        runScrub(3, -1, 4'd0, busy, done);
        checkOutput("t4_busy_cycles", busy, Depth + 4);
        checkOutput("t4_done_pulses", done, 1);
        checkOutput("t4_cnt", err_cnt_o, 2);
        checkOutput("t4_addr", err_addr_o, 4);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        checkOutput("t4_rdata0", rdata_o, 64'hA5A5_0000_1111_2222);
        checkOutput("t4_rerr0", rerr_o, 0);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, 4'd11, 1'b0, 1'b0);
        checkOutput("t4_rdata11", rdata_o, 64'h8000_0000_0000_0001);
        checkOutput("t4_rerr11", rerr_o, 0);
        idleCycle();

        // Saturation, simultaneous read+scrub error, clear coinciding with error
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        dut.data_q[2] = 64'h6;
        dut.data_q[5] = 64'h6;
        dut.data_q[7] = 64'h6;
        dut.data_q[8] = 64'h6;
        runScrub(-1, 1, 4'd5, busy, done);
        checkOutput("t5_sat_cnt", err_cnt_o, 3);
        checkOutput("t5_addr", err_addr_o, 2);
        checkOutput("t5_err", ecc_err_o, 1);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b1, 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("t5_clr_hit_err", ecc_err_o, 1);
        checkOutput("t5_clr_hit_cnt", err_cnt_o, 1);
        checkOutput("t5_clr_hit_addr", err_addr_o, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
